cansec_icv_check: RTL

Downstream consumer of the AES encryption control block in the CAN XL / CANsec receive path. Captures the 128-bit AES result on its done strobe and truncates it to the configured ICV length. Compares it byte-serially, in constant time, against the ICV field extracted from the received frame. Reports authentication pass/fail, times out if the AES core never completes, and keeps a saturating failure counter for the error-management logic.

---
 rtl/cansec_icv_check.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cansec_icv_check.sv
`default_nettype none
// ============================================================================
// cansec_icv_check : constant-time CANsec ICV comparison against AES result
// Rev 1.0
// ============================================================================
module cansec_icv_check #(
   parameter int ICV_BYTES   = 16,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic         clk,
   input  logic         g_rst,
   input  logic         start,
   input  logic [127:0] icv_rcvd,
   input  logic [127:0] aes_data,
   input  logic         aes_done,
   input  logic         tx_success,
   input  logic         rx_success,
   output logic         busy,
   output logic         result_valid,
   output logic         auth_ok,
   output logic         auth_fail,
   output logic         timeout,
   output logic [7:0]   fail_count
);

   localparam logic [1:0]  S_IDLE    = 2'd0;
   localparam logic [1:0]  S_WAIT    = 2'd1;
   localparam logic [1:0]  S_COMPARE = 2'd2;
   localparam logic [1:0]  S_REPORT  = 2'd3;

   localparam logic [3:0]  LAST_IDX  = 4'(ICV_BYTES - 1);
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

   logic [1:0]   state;
   logic [1:0]   state_nxt;
   logic         aes_done_q;
   logic [127:0] icv_q;
   logic [127:0] tag_q;
   logic [7:0]   mismatch;
   logic [15:0]  wait_cnt;
   logic [3:0]   idx;
   logic         forced_fail;

   logic         aes_edge;
   logic         clear;
   logic         wait_expired;
   logic [6:0]   byte_lo;
   logic         accept;
   logic         capture;
   logic         expire;
   logic         count_wait;
   logic         compare_step;
   logic         report;
   logic         verdict_ok;

   assign aes_edge     = aes_done & ~aes_done_q;
   assign clear        = tx_success | rx_success;
   assign wait_expired = (wait_cnt == WAIT_LAST);
   // Byte 0 sits at bits 127:120, so byte idx starts at bit 8*(15-idx).
   assign byte_lo      = {~idx, 3'b000};

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or posedge g_rst) begin
      if (g_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:    if (start) state_nxt = S_WAIT;
            S_WAIT:    if (aes_edge) state_nxt = S_COMPARE;
                       else if (wait_expired) state_nxt = S_REPORT;
            S_COMPARE: if (idx == LAST_IDX) state_nxt = S_REPORT;
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- output decode
   always_comb begin
      accept       = 1'b0;
      capture      = 1'b0;
      expire       = 1'b0;
      count_wait   = 1'b0;
      compare_step = 1'b0;
      report       = 1'b0;
      if (!clear) begin
         case (state)
            S_IDLE:    accept = start;
            S_WAIT: begin
               capture    = aes_edge;
               expire     = ~aes_edge & wait_expired;
               count_wait = ~aes_edge & ~wait_expired;
            end
            S_COMPARE: compare_step = 1'b1;
            default:   report = 1'b1;
         endcase
      end
      verdict_ok = (mismatch == 8'd0) & ~forced_fail;
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge g_rst) begin
      if (g_rst) begin
         aes_done_q   <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         auth_ok      <= 1'b0;
         auth_fail    <= 1'b0;
         timeout      <= 1'b0;
         fail_count   <= 8'd0;
         icv_q        <= '0;
         tag_q        <= '0;
         mismatch     <= 8'd0;
         wait_cnt     <= 16'd0;
         idx          <= 4'd0;
         forced_fail  <= 1'b0;
      end else begin
         aes_done_q   <= aes_done;
         busy         <= (state_nxt != S_IDLE);
         result_valid <= report;

         if (clear || accept) begin
            auth_ok   <= 1'b0;
            auth_fail <= 1'b0;
            timeout   <= 1'b0;
         end else if (report) begin
            auth_ok   <= verdict_ok;
            auth_fail <= ~verdict_ok;
            timeout   <= forced_fail;
            if (!verdict_ok && fail_count != 8'hff)
               fail_count <= fail_count + 8'd1;
         end

         if (accept) begin
            icv_q       <= icv_rcvd;
            mismatch    <= 8'd0;
            wait_cnt    <= 16'd0;
            forced_fail <= 1'b0;
         end
         if (capture) begin
            tag_q <= aes_data;
            idx   <= 4'd0;
         end
         if (count_wait) wait_cnt <= wait_cnt + 16'd1;
         if (expire) forced_fail <= 1'b1;
         // Every configured byte is folded in regardless of earlier mismatches.
         if (compare_step) begin
            mismatch <= mismatch | (tag_q[byte_lo +: 8] ^ icv_q[byte_lo +: 8]);
            idx      <= idx + 4'd1;
         end
      end
   end

endmodule
`default_nettype wire
